// File: rtl/led_sequencer.sv
// led_sequencer: three-LED RGB colour cycler with per-tick fading, hold phase and registered PWM drive
module led_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int HOLD_TICKS = 250,
  parameter int FADE_STEP = 1
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       run,
  input  logic       pause,
  output logic       red_0,
  output logic       green_0,
  output logic       blue_0,
  output logic       red_1,
  output logic       green_1,
  output logic       blue_1,
  output logic       red_2,
  output logic       green_2,
  output logic       blue_2,
  output logic       busy,
  output logic       holding,
  output logic [1:0] color_index
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] pwm_cnt;
  logic [DW-1:0] div, div_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [1:0] idx_nx;
  logic [7:0] duty [9];
  logic [7:0] duty_nx [9];
  logic [7:0] fade [9];
  logic [7:0] tgt [9];
  logic [8:0] led;
  logic tick, settled;
  always_comb begin
    tick = state != IDLE && !pause && div == DW'(TICK_DIV - 1);
    settled = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tgt[i] = (color_index + 2'(i / 3) == 2'd3 || color_index + 2'(i / 3) == 2'(i % 3)) ? 8'hff : 8'h00;
      fade[i] = tgt[i] > duty[i]
        ? (tgt[i] - duty[i] > 8'(FADE_STEP) ? duty[i] + 8'(FADE_STEP) : tgt[i])
        : (duty[i] - tgt[i] > 8'(FADE_STEP) ? duty[i] - 8'(FADE_STEP) : tgt[i]);
      settled = settled && fade[i] == tgt[i];
    end
    state_nx = state;
    div_nx = div;
    hold_nx = hold_cnt;
    idx_nx = color_index;
    duty_nx = duty;
    if (state != IDLE && !run) begin
      state_nx = IDLE;
      div_nx = '0;
      hold_nx = '0;
      idx_nx = '0;
      duty_nx = '{default: '0};
    end else if (!pause) begin
      div_nx = (state == IDLE || tick) ? '0 : div + 1'b1;
      if (state == IDLE && run) begin
        state_nx = FADE;
        idx_nx = '0;
      end else if (state == FADE && tick) begin
        duty_nx = fade;
        state_nx = settled ? HOLD : FADE;
        hold_nx = settled ? '0 : hold_cnt;
      end else if (state == HOLD && tick) begin
        state_nx = hold_cnt == HW'(HOLD_TICKS - 1) ? FADE : HOLD;
        idx_nx = hold_cnt == HW'(HOLD_TICKS - 1) ? color_index + 2'd1 : color_index;
        hold_nx = hold_cnt == HW'(HOLD_TICKS - 1) ? '0 : hold_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      pwm_cnt <= '0;
      div <= '0;
      hold_cnt <= '0;
      color_index <= '0;
      duty <= '{default: '0};
      led <= '0;
    end else begin
      state <= state_nx;
      pwm_cnt <= pwm_cnt + 8'd1;
      div <= div_nx;
      hold_cnt <= hold_nx;
      color_index <= idx_nx;
      duty <= duty_nx;
      for (int i = 0; i < 9; i++) led[i] <= pwm_cnt < duty[i];
    end
  end
  assign {blue_2, green_2, red_2, blue_1, green_1, red_1, blue_0, green_0, red_0} = led;
  assign busy = state != IDLE;
  assign holding = state == HOLD;
endmodule
